// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit owning HI/LO. The optional flush input is enabled by defining MULDIV_FLUSH_EN.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
`ifdef MULDIV_FLUSH_EN
    input  logic             flush,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d;
    logic                 div_q, div_d, dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 flush_w;

`ifdef MULDIV_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Operand magnitudes: op[0]=0 selects the signed variants.
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign sign_a = ~op[0] & srca[WIDTH-1];
    assign sign_b = ~op[0] & srcb[WIDTH-1];
    assign abs_a  = sign_a ? -srca : srca;
    assign abs_b  = sign_b ? -srcb : srcb;

    // One shift-add step: product upper half accumulates, multiplier drains from the low end.
    logic [WIDTH:0] msum;
    assign msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};

    // One restoring step: a set top bit of the difference means the trial subtraction underflowed.
    logic [WIDTH:0] dshift, ddiff;
    assign dshift = {rem_q, quo_q[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, b_q};

    // Sign-corrected results; divide-by-zero forces an all-ones quotient.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = qneg_q ? -prod_q : prod_q;
    assign quo_fix  = dz_q ? {WIDTH{1'b1}} : (qneg_q ? -quo_q : quo_q);
    assign rem_fix  = rneg_q ? -rem_q : rem_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state: WIDTH iterations in RUN, one writeback cycle in FIX; flush aborts either.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = flush_w ? IDLE : (cnt_q == CNT_W'(WIDTH - 1) ? FIX : RUN);
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch on start, iterate in RUN, write HI/LO in FIX, service moves only in idle.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        dz_d   = dz_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (state_q == IDLE && start) begin
            cnt_d  = '0;
            a_d    = abs_a;
            b_d    = abs_b;
            prod_d = {{WIDTH{1'b0}}, abs_b};
            rem_d  = '0;
            quo_d  = abs_a;
            div_d  = op[1];
            dz_d   = (srcb == '0);
            qneg_d = sign_a ^ sign_b;
            rneg_d = sign_a;
        end else if (state_q == IDLE) begin
            if (mthi) hi_d = srca;
            if (mtlo) lo_d = srca;
        end else if (state_q == RUN) begin
            cnt_d  = cnt_q + 1'b1;
            prod_d = {msum, prod_q[WIDTH-1:1]};
            rem_d  = ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
            quo_d  = {quo_q[WIDTH-2:0], ~ddiff[WIDTH]};
        end else if (state_q == FIX && !flush_w) begin
            hi_d   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_d   = div_q ? quo_fix : prod_fix[WIDTH-1:0];
            done_d = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  srca = '0, srcb = '0;
`ifdef MULDIV_FLUSH_EN
    logic          flush = 1'b0;
`endif
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int            errors = 0, checks = 0;
    logic [W-1:0]  mhi = '0, mlo = '0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mthi(mthi), .mtlo(mtlo),
`ifdef MULDIV_FLUSH_EN
        .flush(flush),
`endif
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb, q, r;
        longint p;
        sa = a;
        sb = b;
        if (o == 2'd0) begin
            p = longint'(sa) * longint'(sb);
            return p;
        end
        if (o == 2'd1) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Runs one operation and checks timing, hold behaviour and the final HI/LO.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit mt_during, input bit mv_with_start);
        logic [63:0] e;
        logic [31:0] oh, ol;
        int          bc, dc, dat;
        bit          held;
        oh = mhi;
        ol = mlo;
        e  = ref_model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        mthi = mv_with_start; mtlo = mv_with_start;
        bc = 0; dc = 0; dat = -1; held = 1'b1;
        for (int k = 0; k <= W + 2; k++) begin
            @(negedge clk);
            start = 1'b0; mthi = 1'b0;
            mtlo = (mt_during && k == 3);
            if (mt_during && k == 3) srca = 32'hDEAD_BEEF;
            if (busy) bc++;
            if (done) begin dc++; dat = k; end
            if (k <= W && (hi !== oh || lo !== ol)) held = 1'b0;
            if (k == W + 1) begin
                check("hi", hi, e[63:32]);
                check("lo", lo, e[31:0]);
            end
        end
        mtlo = 1'b0;
        check("busy_cycles", bc, W + 1);
        check("done_count", dc, 1);
        check("done_at", dat, W + 1);
        check("hold", held, 1);
        mhi = e[63:32];
        mlo = e[31:0];
    endtask

    task automatic move(input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        mthi = h; mtlo = l; srca = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (h) mhi = v;
        if (l) mlo = v;
        check("mv_hi", hi, mhi);
        check("mv_lo", lo, mlo);
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int dc;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
        run_op(2'd2, -32'sd7, 32'd2, 0, 0);
        run_op(2'd3, 32'd100, 32'd7, 0, 0);
        run_op(2'd3, 32'd5, 32'd0, 0, 0);
        run_op(2'd2, -32'sd9, 32'd0, 0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);

        move(1'b1, 1'b0, 32'h1234_5678);
        run_op(2'd1, 32'd2, 32'd3, 1, 0);
        move(1'b1, 1'b1, 32'hCAFE_F00D);
        run_op(2'd3, 32'd77, 32'd5, 0, 1);

        for (int i = 0; i < 40; i++) run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);

        move(1'b1, 1'b1, 32'hA5A5_0001);
        launch(2'd3, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_hi", hi, 0);
        check("async_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mhi = '0; mlo = '0;
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("post_rst_done", dc, 0);
        check("post_rst_busy", busy, 0);

`ifdef MULDIV_FLUSH_EN
        move(1'b1, 1'b1, 32'h0BAD_F00D);
        launch(2'd3, 32'd500, 32'd7);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_busy", busy, 0);
        check("fl_hi", hi, mhi);
        check("fl_lo", lo, mlo);
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("fl_done", dc, 0);
        launch(2'd1, 32'd9, 32'd9);
        repeat (W - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flfix_busy", busy, 0);
        check("flfix_done", done, 0);
        check("flfix_lo", lo, mlo);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1; op = 2'd1; srca = 32'd4; srcb = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("fl_idle_busy", busy, 1);
        repeat (W + 2) @(negedge clk);
        check("fl_idle_lo", lo, 32'd20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
